mib_slave: RTL
==============

Name: mib_slave

Overview:
- Responder end of the MIB (16-bit multiplexed address/data) bus; one instance per FPGA behind the board-level MIB pads.
- Decodes MIB address and write-data phases from the master and selects on the address MSN.
- Issues a single command-bus transaction (sel / rd_wr_n / byte_addr / wdata, completed by ack / rdata) to the local register fabric.
- Returns the write ACK, or two read-data phases with ACK, back onto MIB.

Parameters:
- P_SLAVE_MSN, 4'h0, value of byte_addr[23:20] this slave answers to.
- P_CMD_ACK_TIMEOUT_CLKS, 16, clocks to wait for i_cmd_ack before abandoning the transaction.
- P_TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned on command timeout.

Ports:
- i_sysclk  in  1  sole clock; MIB and command bus are synchronous to it.
- i_arst_n  in  1  asynchronous active-low reset.
- i_mib_start  in  1  one-clock pulse marking address phase 1 (registered at the pad).
- i_mib_rd_wr_n  in  1  1 = read, 0 = write; valid with i_mib_start.
- i_mib_ad  in  16  master-driven address/write-data (registered at the pad).
- o_mib_ad  out  16  slave read data.
- o_mib_ad_oe  out  1  1 = top level drives the pad from o_mib_ad, 0 = tri-state.
- o_mib_slave_ack  out  1  write ack, or read-data-valid strobe.
- o_cmd_sel  out  1  one-clock command request.
- o_cmd_rd_wr_n  out  1  command direction.
- o_cmd_byte_addr  out  24  command byte address.
- o_cmd_wdata  out  32  command write data.
- i_cmd_ack  in  1  command completion.
- i_cmd_rdata  in  32  read data, valid with i_cmd_ack.
- o_cmd_timeout  out  1  one-clock pulse when the command timeout fires.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, timeout counter 0.
  - Reset is asynchronous; an assertion mid-transaction aborts it immediately.
  - The in-flight command is dropped; a late i_cmd_ack after reset is ignored in IDLE.
- MIB phase format, in consecutive clocks:
  - A1 (start = 1): ad = {8'h00, addr[23:16]}.
  - A2: ad = addr[15:0].
  - Write only: W1 = wdata[31:16], W2 = wdata[15:0].
- FSM states and transitions:
  - IDLE: on i_mib_start, latch rd_wr_n and A1 -> ADDR2.
  - ADDR2: latch addr[15:0].
    - If addr[23:20] != P_SLAVE_MSN -> IDLE (no response, pad never driven).
    - Else if write -> WDATA1.
    - Else -> CMD_ISSUE.
  - WDATA1: latch wdata[31:16] -> WDATA2.
  - WDATA2: latch wdata[15:0] -> CMD_ISSUE.
  - CMD_ISSUE: o_cmd_sel = 1 for exactly one clock; byte_addr, rd_wr_n and wdata are held stable until leaving CMD_WAIT -> CMD_WAIT.
  - CMD_WAIT: count clocks.
    - i_cmd_ack: capture i_cmd_rdata -> RD_HI (read) or WR_ACK (write).
    - Count reaches P_CMD_ACK_TIMEOUT_CLKS with no ack: pulse o_cmd_timeout, load P_TIMEOUT_RDATA for reads, take the same exits.
    - If ack and timeout coincide, ack wins and no timeout pulse is issued.
  - WR_ACK: o_mib_slave_ack = 1 for one clock -> IDLE.
  - RD_HI: oe = 1, ad = rdata[31:16], ack = 1 -> RD_LO.
  - RD_LO: oe = 1, ad = rdata[15:0], ack = 1 -> IDLE.
- Bus turnaround:
  - oe is always 0 in every state other than RD_HI and RD_LO.
  - At least one idle clock (CMD_ISSUE) separates master A2 from the slave driving the pad.
- All of o_mib_ad, o_mib_ad_oe and o_mib_slave_ack are registered; no combinational path from MIB inputs to outputs.
- Minimum latency, A1 to first ack:
  - Read: 4 clocks when i_cmd_ack arrives in the first CMD_WAIT clock.
  - Write: 6 clocks on the same condition.
- i_mib_start outside IDLE is ignored; the current transaction completes.
- Addresses are passed through unmodified. The low two bits are not checked, and the MSN remains in o_cmd_byte_addr.
- Back-to-back transactions: a new A1 is accepted in the clock immediately after RD_LO or WR_ACK.

Decomposition:
- Package mib_pkg:
  - Typedef for the FSM state enum.
  - Constants MIB_AD_BITS = 16, CMD_ADDR_BITS = 24, CMD_DATA_BITS = 32.
  - MSN field position [23:20].
  - The same package is reused by the MIB master.
- No sub-module is needed. The timeout counter is inline, $clog2(P_CMD_ACK_TIMEOUT_CLKS+1) bits wide.

Test Plan:
1. Write 0x000004 <- 0x01010202, cmd ack 2 clocks after sel:
   - o_cmd_sel pulses once with byte_addr 0x000004, wdata 0x01010202, rd_wr_n 0.
   - Single o_mib_slave_ack one clock after i_cmd_ack; oe stays 0 throughout.
2. Read 0x000004 with i_cmd_rdata 0x01010202:
   - oe high exactly two clocks; ad 0x0101 then 0x0202, ack high on both.
   - oe low the clock before and after.
3. Read 0x100008 with P_SLAVE_MSN = 0:
   - No o_cmd_sel, no ack, oe never asserted; FSM back in IDLE after A2.
4. Read 0x000008 with i_cmd_ack withheld:
   - o_cmd_timeout pulses after 16 CMD_WAIT clocks.
   - MIB returns 0xDEAD, 0xBEEF with ack.
5. Write 0x00000C, i_arst_n low for 1 clock during CMD_WAIT:
   - All outputs 0 immediately (asynchronously); later i_cmd_ack produces no MIB ack.
   - Next read 0x000000 completes normally.
6. Back-to-back write then read with A1 the clock after WR_ACK:
   - Both complete; i_mib_start injected mid-read is ignored with no corruption.

Source files
------------

// File: rtl/mib_pkg.sv
// Shared MIB definitions: bus widths, command address fields and the responder FSM states.
// Used by both ends of the MIB link.
package mib_pkg;

  localparam int MIB_AD_BITS   = 16;
  localparam int CMD_ADDR_BITS = 24;
  localparam int CMD_DATA_BITS = 32;

  // Module-select nibble inside the command byte address.
  localparam int MSN_HI = 23;
  localparam int MSN_LO = 20;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR2,
    ST_WDATA1,
    ST_WDATA2,
    ST_CMD_ISSUE,
    ST_CMD_WAIT,
    ST_WR_ACK,
    ST_RD_HI,
    ST_RD_LO
  } mib_state_e;

  function automatic logic [3:0] addr_msn(input logic [CMD_ADDR_BITS-1:0] addr);
    return addr[MSN_HI:MSN_LO];
  endfunction

endpackage

// File: rtl/mib_slave.sv
// MIB responder: decodes address/write-data phases, runs one command-bus transaction
// and returns a write ack or two read-data phases. Every output is a register.
module mib_slave
  import mib_pkg::*;
#(
  parameter logic [3:0]  P_SLAVE_MSN            = 4'h0,
  parameter int          P_CMD_ACK_TIMEOUT_CLKS = 16,
  parameter logic [31:0] P_TIMEOUT_RDATA        = 32'hDEAD_BEEF
) (
  input  logic                     i_sysclk,
  input  logic                     i_arst_n,
  input  logic                     i_mib_start,
  input  logic                     i_mib_rd_wr_n,
  input  logic [MIB_AD_BITS-1:0]   i_mib_ad,
  output logic [MIB_AD_BITS-1:0]   o_mib_ad,
  output logic                     o_mib_ad_oe,
  output logic                     o_mib_slave_ack,
  output logic                     o_cmd_sel,
  output logic                     o_cmd_rd_wr_n,
  output logic [CMD_ADDR_BITS-1:0] o_cmd_byte_addr,
  output logic [CMD_DATA_BITS-1:0] o_cmd_wdata,
  input  logic                     i_cmd_ack,
  input  logic [CMD_DATA_BITS-1:0] i_cmd_rdata,
  output logic                     o_cmd_timeout
);

  localparam int                CNT_W    = $clog2(P_CMD_ACK_TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(P_CMD_ACK_TIMEOUT_CLKS - 1);

  mib_state_e               state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     rd_wr_n_q;
  logic [CMD_ADDR_BITS-1:0] addr_q;
  logic [CMD_DATA_BITS-1:0] wdata_q;
  logic [MIB_AD_BITS-1:0]   rdata_lo_q;
  logic [MIB_AD_BITS-1:0]   mib_ad_q;
  logic                     mib_oe_q;
  logic                     mib_ack_q;
  logic                     cmd_sel_q;
  logic                     cmd_timeout_q;

  logic                     cmd_done;
  logic [CMD_DATA_BITS-1:0] resp_data;

  // An ack in the final counted clock beats the timeout.
  assign cmd_done  = i_cmd_ack || (cnt_q == CNT_LAST);
  assign resp_data = i_cmd_ack ? i_cmd_rdata : P_TIMEOUT_RDATA;

  always_ff @(posedge i_sysclk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      // NOTE: the datapath registers drive ports directly, so they are reset along with the FSM.
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rd_wr_n_q     <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_lo_q    <= '0;
      mib_ad_q      <= '0;
      mib_oe_q      <= 1'b0;
      mib_ack_q     <= 1'b0;
      cmd_sel_q     <= 1'b0;
      cmd_timeout_q <= 1'b0;
    end else begin
      mib_ad_q      <= '0;
      mib_oe_q      <= 1'b0;
      mib_ack_q     <= 1'b0;
      cmd_sel_q     <= 1'b0;
      cmd_timeout_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (i_mib_start) begin
            rd_wr_n_q     <= i_mib_rd_wr_n;
            addr_q[23:16] <= i_mib_ad[7:0];
            state_q       <= ST_ADDR2;
          end
        end
        ST_ADDR2: begin
          addr_q[15:0] <= i_mib_ad;
          if (addr_msn(addr_q) != P_SLAVE_MSN) begin
            state_q <= ST_IDLE;
          end else if (!rd_wr_n_q) begin
            state_q <= ST_WDATA1;
          end else begin
            cmd_sel_q <= 1'b1;
            state_q   <= ST_CMD_ISSUE;
          end
        end
        ST_WDATA1: begin
          wdata_q[31:16] <= i_mib_ad;
          state_q        <= ST_WDATA2;
        end
        ST_WDATA2: begin
          wdata_q[15:0] <= i_mib_ad;
          cmd_sel_q     <= 1'b1;
          state_q       <= ST_CMD_ISSUE;
        end
        ST_CMD_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_CMD_WAIT;
        end
        ST_CMD_WAIT: begin
          if (cmd_done) begin
            cmd_timeout_q <= !i_cmd_ack;
            rdata_lo_q    <= resp_data[15:0];
            if (rd_wr_n_q) begin
              mib_ad_q  <= resp_data[31:16];
              mib_oe_q  <= 1'b1;
              mib_ack_q <= 1'b1;
              state_q   <= ST_RD_HI;
            end else begin
              mib_ack_q <= 1'b1;
              state_q   <= ST_WR_ACK;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_WR_ACK: state_q <= ST_IDLE;
        ST_RD_HI: begin
          mib_ad_q  <= rdata_lo_q;
          mib_oe_q  <= 1'b1;
          mib_ack_q <= 1'b1;
          state_q   <= ST_RD_LO;
        end
        ST_RD_LO: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_mib_ad        = mib_ad_q;
  assign o_mib_ad_oe     = mib_oe_q;
  assign o_mib_slave_ack = mib_ack_q;
  assign o_cmd_sel       = cmd_sel_q;
  assign o_cmd_rd_wr_n   = rd_wr_n_q;
  assign o_cmd_byte_addr = addr_q;
  assign o_cmd_wdata     = wdata_q;
  assign o_cmd_timeout   = cmd_timeout_q;

endmodule
